// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one uart_tx transmitter between two requesters: the
//            1-byte keystroke echo and the up-to-MAX_LEN-byte result/prompt
//            string. One requester is granted, its bytes are shifted out
//            MSB-first onto tx_data/tx_wr_en, and bytes are paced by the
//            transmitter's tx_sent flag plus a fixed inter-byte gap.
//            Runs in the baud clock domain.
// Config   : ARB_ROUND_ROBIN_EN defined   -> simultaneous requests go to the
//                                             requester not granted last.
//            ARB_ROUND_ROBIN_EN undefined -> fixed priority, echo wins.
// Ports    : clk        in   baud-domain clock
//            reset_n    in   asynchronous active-low reset
//            req_echo   in   level request, held until echo_done
//            echo_byte  in   byte to echo, sampled at grant
//            echo_done  out  1-cycle pulse when the echo transfer completes
//            req_str    in   level request, held until str_done
//            str_buf    in   string, byte 0 in the top 8 bits, sampled at grant
//            str_len    in   bytes to send (0 allowed, clamped to MAX_LEN)
//            str_done   out  1-cycle pulse when the string transfer completes
//            tx_sent    in   uart_tx idle/ready flag
//            tx_data    out  byte to uart_tx, held until the next load
//            tx_wr_en   out  1-cycle write strobe to uart_tx
//            busy       out  high whenever the arbiter is not idle
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int MAX_LEN    = 20,
    parameter int LEN_W      = 5,
    parameter int GAP_CYCLES = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_echo,
    input  logic [7:0]           echo_byte,
    output logic                 echo_done,
    input  logic                 req_str,
    input  logic [MAX_LEN*8-1:0] str_buf,
    input  logic [LEN_W-1:0]     str_len,
    output logic                 str_done,
    input  logic                 tx_sent,
    output logic [7:0]           tx_data,
    output logic                 tx_wr_en,
    output logic                 busy
);

    localparam int c_BUF_W = MAX_LEN * 8;
    localparam int c_REM_W = $clog2(MAX_LEN + 1);
    // Gap counter runs 0..GAP_CYCLES-1 while in S_GAP.
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYCLES - 1);
    localparam logic [c_REM_W-1:0] c_MAX_REM  = c_REM_W'(MAX_LEN);
    localparam logic [c_REM_W-1:0] c_ONE_REM  = c_REM_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_STROBE   = 3'd2,
        S_GAP      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_BUF_W-1:0]  r_shift;
    logic [c_REM_W-1:0]  r_remaining;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic                r_grant_echo;
`ifdef ARB_ROUND_ROBIN_EN
    logic                r_last_echo;
`endif

    logic                w_pick_echo;
    logic [c_REM_W-1:0]  w_str_count;
    logic [c_BUF_W-1:0]  w_echo_load;

    // Arbitration: only meaningful while idle with at least one request.
    always_comb begin
        w_pick_echo = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        // On contention, the side that was not served last wins.
        w_pick_echo = req_echo && (!req_str || !r_last_echo);
`else
        w_pick_echo = req_echo;
`endif
    end

    always_comb begin
        w_str_count = c_REM_W'(str_len);
        if (32'(str_len) > MAX_LEN) begin
            w_str_count = c_MAX_REM;
        end
    end

    // Echo byte is placed where string byte 0 would sit so both requesters
    // share the same top-byte extraction path.
    assign w_echo_load = c_BUF_W'(echo_byte) << (c_BUF_W - 8);

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_remaining  <= '0;
            r_gap_cnt    <= '0;
            r_grant_echo <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_echo  <= 1'b0;
`endif
            tx_data      <= 8'h00;
            tx_wr_en     <= 1'b0;
            echo_done    <= 1'b0;
            str_done     <= 1'b0;
        end else begin
            // Pulsed outputs default low and are raised for one cycle only.
            tx_wr_en  <= 1'b0;
            echo_done <= 1'b0;
            str_done  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req_echo || req_str) begin
                        r_grant_echo <= w_pick_echo;
                        if (w_pick_echo) begin
                            r_shift     <= w_echo_load;
                            r_remaining <= c_ONE_REM;
                            r_state     <= S_WAIT_RDY;
                        end else begin
                            r_shift     <= str_buf;
                            r_remaining <= w_str_count;
                            r_state     <= (w_str_count == '0) ? S_DONE : S_WAIT_RDY;
                        end
                    end
                end

                S_WAIT_RDY: begin
                    // The strobe is only issued after tx_sent was seen high,
                    // so tx_wr_en can never coincide with a busy transmitter.
                    if (tx_sent) begin
                        tx_data     <= r_shift[c_BUF_W-1 -: 8];
                        r_shift     <= r_shift << 8;
                        r_remaining <= r_remaining - 1'b1;
                        tx_wr_en    <= 1'b1;
                        r_state     <= S_STROBE;
                    end
                end

                S_STROBE: begin
                    r_gap_cnt <= '0;
                    r_state   <= S_GAP;
                end

                S_GAP: begin
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= (r_remaining != '0) ? S_WAIT_RDY : S_DONE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    echo_done   <= r_grant_echo;
                    str_done    <= !r_grant_echo;
`ifdef ARB_ROUND_ROBIN_EN
                    r_last_echo <= r_grant_echo;
`endif
                    r_state     <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. A transaction-level
//            model predicts, per request pattern, the order of grants and the
//            exact byte list each grant must put on the transmitter; a
//            negedge monitor scores every strobe and done pulse against it.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int MAX_LEN = 20;
    localparam int LEN_W   = 5;
    localparam int GAP     = 20;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 req_echo;
    logic [7:0]           echo_byte;
    logic                 echo_done;
    logic                 req_str;
    logic [MAX_LEN*8-1:0] str_buf;
    logic [LEN_W-1:0]     str_len;
    logic                 str_done;
    logic                 tx_sent;
    logic [7:0]           tx_data;
    logic                 tx_wr_en;
    logic                 busy;

    uart_tx_arbiter #(
        .MAX_LEN    (MAX_LEN),
        .LEN_W      (LEN_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_echo  (req_echo),
        .echo_byte (echo_byte),
        .echo_done (echo_done),
        .req_str   (req_str),
        .str_buf   (str_buf),
        .str_len   (str_len),
        .str_done  (str_done),
        .tx_sent   (tx_sent),
        .tx_data   (tx_data),
        .tx_wr_en  (tx_wr_en),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected traffic: bytes in issue order, and per transaction its kind
    // (1 = echo) and byte count.
    logic [7:0] exp_bytes[$];
    bit         exp_kind[$];
    int         exp_n[$];

    int  cnt_since_done  = 0;
    int  cyc             = 0;
    int  last_strobe_cyc = 0;
    int  last_spacing    = 0;
    int  strobe_total    = 0;
    int  busy_left       = 0;
    int  busy_max        = 0;
    bit  force_busy      = 1'b0;
    bit  model_last_echo = 1'b0;

    assign tx_sent = (busy_left == 0) && !force_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor + transmitter model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n === 1'b1) begin
                if (tx_wr_en) begin
                    strobe_total++;
                    chk("wr_en_while_tx_busy", 32'(tx_sent), 32'd1);
                    chk("strobe_has_pending", 32'(exp_bytes.size() != 0), 32'd1);
                    if (exp_bytes.size() != 0) begin
                        chk("strobe_data", 32'(tx_data), 32'(exp_bytes.pop_front()));
                    end
                    if (cnt_since_done > 0) begin
                        last_spacing = cyc - last_strobe_cyc;
                        chk("strobe_spacing_min", 32'(last_spacing >= GAP + 2), 32'd1);
                    end
                    last_strobe_cyc = cyc;
                    cnt_since_done++;
                end
                if (echo_done || str_done) begin
                    chk("done_exclusive", 32'(echo_done && str_done), 32'd0);
                    chk("done_has_pending", 32'(exp_kind.size() != 0), 32'd1);
                    if (exp_kind.size() != 0) begin
                        chk("done_kind_echo", 32'(echo_done), 32'(exp_kind.pop_front()));
                        chk("bytes_per_txn", 32'(cnt_since_done), 32'(exp_n.pop_front()));
                    end
                    cnt_since_done = 0;
                end
            end
            // Transmitter goes busy for a random time after each write.
            if (tx_wr_en) busy_left = (busy_max == 0) ? 0 : int'($urandom_range(0, busy_max));
            else if (busy_left > 0) busy_left--;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_echo(input logic [7:0] b);
        exp_bytes.push_back(b);
        exp_kind.push_back(1'b1);
        exp_n.push_back(1);
    endtask

    task automatic push_str(input logic [MAX_LEN*8-1:0] s, input int len);
        int n;
        n = (len > MAX_LEN) ? MAX_LEN : len;
        for (int i = 0; i < n; i++) begin
            exp_bytes.push_back(8'((s >> (8 * (MAX_LEN - 1 - i))) & 'hFF));
        end
        exp_kind.push_back(1'b0);
        exp_n.push_back(n);
    endtask

    // Grant-order model: contention resolved by priority or alternation,
    // the loser is served right after because its request is still held.
    task automatic predict(input bit e, input bit s, input logic [7:0] eb,
                           input logic [MAX_LEN*8-1:0] sb, input int len);
        bit echo_first;
        if (e && s) begin
`ifdef ARB_ROUND_ROBIN_EN
            echo_first = !model_last_echo;
`else
            echo_first = 1'b1;
`endif
        end else begin
            echo_first = e;
        end
        if (echo_first) begin
            push_echo(eb);
            if (s) push_str(sb, len);
        end else begin
            push_str(sb, len);
            if (e) push_echo(eb);
        end
        model_last_echo = (e && s) ? !echo_first : e;
    endtask

    // Raise the requested lines, then drop each as its done pulse appears.
    task automatic run(input bit e, input bit s, input logic [7:0] eb,
                       input logic [MAX_LEN*8-1:0] sb, input int len);
        int need;
        int budget;
        int it;
        @(negedge clk);
        echo_byte = eb;
        str_buf   = sb;
        str_len   = LEN_W'(len);
        req_echo  = e;
        req_str   = s;
        predict(e, s, eb, sb, len);
        need   = int'(e) + int'(s);
        budget = 4000;
        it     = 0;
        while (need > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            it++;
            if (echo_done) begin req_echo = 1'b0; need--; end
            if (str_done)  begin req_str  = 1'b0; need--; end
            // Inputs are sampled at grant; later changes must be ignored.
            if (it == 3 && !(e && s)) begin
                echo_byte = ~echo_byte;
                str_buf   = ~str_buf;
            end
        end
        chk("txn_completed", 32'(need), 32'd0);
        req_echo = 1'b0;
        req_str  = 1'b0;
    endtask

    initial begin
        int m;
        int base;
        int nseen;
        logic [MAX_LEN*8-1:0] sb;
        logic [7:0] eb;
        int len;
        int kind;

        reset_n   = 1'b0;
        req_echo  = 1'b0;
        req_str   = 1'b0;
        echo_byte = 8'h00;
        str_buf   = '0;
        str_len   = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx_wr_en", 32'(tx_wr_en), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dones", 32'({echo_done, str_done}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Echo latency and data.
        echo_byte = 8'h37;
        req_echo  = 1'b1;
        predict(1'b1, 1'b0, 8'h37, '0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("echo_no_early_strobe", 32'(tx_wr_en), 32'd0);
        chk("echo_busy", 32'(busy), 32'd1);
        @(negedge clk);
        m = 1;
        chk("echo_strobe_at_n2", 32'(tx_wr_en), 32'd1);
        chk("echo_data", 32'(tx_data), 32'h37);
        while (!echo_done && m < 200) begin
            @(negedge clk);
            m++;
        end
        chk("echo_done_latency", 32'(m), 32'(GAP + 3));
        req_echo = 1'b0;
        repeat (2) @(negedge clk);

        // Three-byte string with exact spacing.
        sb = '0;
        sb[MAX_LEN*8-1 -: 24] = 24'h0D0A2B;
        base = strobe_total;
        run(1'b0, 1'b1, 8'h00, sb, 3);
        chk("str3_strobe_count", 32'(strobe_total - base), 32'd3);
        chk("str3_spacing", 32'(last_spacing), 32'(GAP + 2));

        // Zero-length string.
        @(negedge clk);
        str_len = '0;
        req_str = 1'b1;
        predict(1'b0, 1'b1, 8'h00, sb, 0);
        base = strobe_total;
        @(posedge clk);
        @(negedge clk);
        chk("len0_no_done_yet", 32'(str_done), 32'd0);
        @(negedge clk);
        chk("len0_done_at_2", 32'(str_done), 32'd1);
        req_str = 1'b0;
        repeat (2) @(negedge clk);
        chk("len0_no_strobe", 32'(strobe_total - base), 32'd0);

        // Over-length string is clamped.
        for (int i = 0; i < MAX_LEN * 8 / 32; i++) sb[32*i +: 32] = $urandom;
        base = strobe_total;
        run(1'b0, 1'b1, 8'h00, sb, 25);
        chk("len25_clamped", 32'(strobe_total - base), 32'(MAX_LEN));

        // Contention, last grant = string, then last grant = echo.
        run(1'b1, 1'b1, 8'h41, sb, 2);
        run(1'b1, 1'b0, 8'h42, sb, 0);
        run(1'b1, 1'b1, 8'h43, sb, 2);

        // Transmitter stalled in WAIT_RDY.
        @(negedge clk);
        force_busy = 1'b1;
        echo_byte  = 8'hA5;
        req_echo   = 1'b1;
        predict(1'b1, 1'b0, 8'hA5, '0, 0);
        base = strobe_total;
        repeat (50) @(negedge clk);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_no_strobe", 32'(strobe_total - base), 32'd0);
        force_busy = 1'b0;
        @(negedge clk);
        chk("stall_strobe_after_ready", 32'(tx_wr_en), 32'd1);
        m = 0;
        while (!echo_done && m < 200) begin
            @(negedge clk);
            m++;
        end
        chk("stall_echo_done", 32'(echo_done), 32'd1);
        req_echo = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during the second of five string bytes.
        @(negedge clk);
        sb = '0;
        sb[MAX_LEN*8-1 -: 40] = 40'h1122334455;
        str_buf = sb;
        str_len = LEN_W'(5);
        req_str = 1'b1;
        predict(1'b0, 1'b1, 8'h00, sb, 5);
        nseen = 0;
        m = 0;
        while (nseen < 2 && m < 1000) begin
            @(negedge clk);
            m++;
            if (tx_wr_en) nseen++;
        end
        chk("rst_mid_reached_byte2", 32'(nseen), 32'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_wr_en", 32'(tx_wr_en), 32'd0);
        chk("rst_mid_tx_data", 32'(tx_data), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        exp_bytes.delete();
        exp_kind.delete();
        exp_n.delete();
        cnt_since_done  = 0;
        model_last_echo = 1'b0;
        req_str = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        base = strobe_total;
        run(1'b0, 1'b1, 8'h00, sb, 5);
        chk("rst_restart_count", 32'(strobe_total - base), 32'd5);

        // Randomized traffic.
        for (int t = 0; t < 25; t++) begin
            kind     = int'($urandom_range(1, 3));
            busy_max = int'($urandom_range(0, 30));
            eb       = 8'($urandom);
            for (int i = 0; i < MAX_LEN * 8 / 32; i++) sb[32*i +: 32] = $urandom;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
            run(kind[0], kind[1], eb, sb, len);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("model_drained", 32'(exp_bytes.size() + exp_kind.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
